// File: rtl/neuron_mac_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : neuron_mac_if
// Description : Activation stream, bias, weight-memory read port and result
//               bundle of a single neuron_mac.
// Revision    : 1.0 - initial release
// ============================================================================
interface neuron_mac_if #(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 10
);
  logic [dataWidth-1:0]   x_in;
  logic                   x_valid;
  logic [2*dataWidth-1:0] bias;
  logic                   w_ren;
  logic [addressWidth:0]  w_raddr;
  logic [dataWidth-1:0]   w_in;
  logic [dataWidth-1:0]   out;
  logic                   out_valid;

  // Upstream / environment side: drives activations, bias and weight data.
  modport master (
    output x_in, x_valid, bias, w_in,
    input  w_ren, w_raddr, out, out_valid
  );

  // Neuron side.
  modport slave (
    input  x_in, x_valid, bias, w_in,
    output w_ren, w_raddr, out, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : neuron_mac
// Description : Fixed-point MAC neuron: dot product of an activation stream
//               with a per-neuron weight memory, plus bias, saturated output.
//               Optional ReLU selected by macro NEURON_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac #(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracBits     = 8
) (
  input  logic        clk,
  input  logic        rst,
  neuron_mac_if.slave bus
);

  localparam int c_ACCW = 2 * dataWidth;
  localparam int c_CNTW = addressWidth + 1;
  localparam logic [c_CNTW-1:0]          c_LAST_IDX = c_CNTW'(numWeight - 1);
  localparam logic signed [c_ACCW-1:0]    c_ACC_MAX  = {1'b0, {(c_ACCW-1){1'b1}}};
  localparam logic signed [c_ACCW-1:0]    c_ACC_MIN  = {1'b1, {(c_ACCW-1){1'b0}}};
  localparam logic signed [dataWidth-1:0] c_OUT_MAX  = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic signed [dataWidth-1:0] c_OUT_MIN  = {1'b1, {(dataWidth-1){1'b0}}};

  function automatic logic signed [c_ACCW-1:0] sat_add(
    input logic signed [c_ACCW-1:0] a,
    input logic signed [c_ACCW-1:0] b
  );
    logic [c_ACCW:0] s;
    s = {a[c_ACCW-1], a} + {b[c_ACCW-1], b};
    if (s[c_ACCW] != s[c_ACCW-1]) begin
      return s[c_ACCW] ? c_ACC_MIN : c_ACC_MAX;
    end
    return s[c_ACCW-1:0];
  endfunction

  // Element counter doubles as the weight read address.
  logic [c_CNTW-1:0] cnt_q, cnt_d;
  logic              cnt_first, cnt_last;

  logic                        s1_valid_q, s1_first_q, s1_last_q;
  logic signed [dataWidth-1:0] x_q;
  logic                        s2_valid_q, s2_first_q, s2_last_q;
  logic signed [c_ACCW-1:0]    prod_q, prod_d;
  logic signed [c_ACCW-1:0]    acc_q, acc_d;
  logic                        done_q;
  logic [dataWidth-1:0]        out_q, out_d;
  logic                        out_valid_q;

  logic signed [c_ACCW-1:0]    sum_d;
  logic signed [c_ACCW-1:0]    shifted;
  logic [c_ACCW-dataWidth:0]   shifted_hi;
  logic signed [dataWidth-1:0] res_sat;
  logic signed [dataWidth-1:0] res_act;

  assign bus.w_ren     = bus.x_valid;
  assign bus.w_raddr   = cnt_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

  always_comb begin
    cnt_first = (cnt_q == '0);
    cnt_last  = (cnt_q == c_LAST_IDX);
    cnt_d     = cnt_q;
    if (bus.x_valid) begin
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
    end
  end

  assign prod_d = x_q * $signed(bus.w_in);

  // The first element loads rather than adds, so vectors need no clear cycle.
  always_comb begin
    acc_d = acc_q;
    if (s2_valid_q) begin
      acc_d = s2_first_q ? prod_q : sat_add(acc_q, prod_q);
    end
  end

  always_comb begin
    sum_d      = sat_add(acc_q, bus.bias);
    shifted    = sum_d >>> fracBits;
    shifted_hi = shifted[c_ACCW-1:dataWidth-1];
    if ((&shifted_hi) || !(|shifted_hi)) begin
      res_sat = shifted[dataWidth-1:0];
    end else begin
      res_sat = shifted[c_ACCW-1] ? c_OUT_MIN : c_OUT_MAX;
    end
`ifdef NEURON_RELU_EN
    res_act = res_sat[dataWidth-1] ? '0 : res_sat;
`else
    res_act = res_sat;
`endif
    out_d = out_q;
    if (done_q) begin
      out_d = res_act;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= bus.x_valid;
      s1_first_q  <= cnt_first;
      s1_last_q   <= cnt_last;
      s2_valid_q  <= s1_valid_q;
      s2_first_q  <= s1_first_q;
      s2_last_q   <= s1_last_q;
      acc_q       <= acc_d;
      done_q      <= s2_valid_q & s2_last_q;
      out_q       <= out_d;
      out_valid_q <= done_q;
    end
  end

  // Datapath registers are qualified by the flags, so they need no reset.
  always_ff @(posedge clk) begin
    if (bus.x_valid) begin
      x_q <= $signed(bus.x_in);
    end
    if (s1_valid_q) begin
      prod_q <= prod_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_neuron_mac
// Description : Randomized and directed bench for neuron_mac with a weight
//               memory model and an arithmetic reference neuron.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;
  localparam int NW = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int FB = 8;

  typedef struct {
    logic [DW-1:0] val;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DW-1:0]   wmem [NW];
  logic [DW-1:0]   vbuf [NW];
  logic [DW-1:0]   xs [$];
  exp_t            expq [$];
  int              ov_q [$];
  logic [DW-1:0]   last_out;

  always #5 clk = ~clk;

  neuron_mac_if #(.dataWidth(DW), .addressWidth(AW)) bus ();

  neuron_mac #(
    .numWeight(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(FB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.w_ren) bus.w_in <= wmem[int'(bus.w_raddr) % NW];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic longint sat(input longint v, input int bits);
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (bits - 1)) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // Reference neuron: sequential saturating dot product, bias, shift, clamp.
  function automatic logic [DW-1:0] model_vec();
    longint acc;
    longint p;
    longint s;
    longint r;
    acc = 0;
    for (int i = 0; i < NW; i++) begin
      p   = longint'($signed(xs[i])) * longint'($signed(wmem[i]));
      acc = (i == 0) ? p : sat(acc + p, 2 * DW);
    end
    s = sat(acc + longint'($signed(bus.bias)), 2 * DW);
    r = sat(s >>> FB, DW);
`ifdef NEURON_RELU_EN
    if (r < 0) r = 0;
`endif
    return DW'(r);
  endfunction

  task automatic cycle(input logic v, input logic [DW-1:0] x, input logic r);
    exp_t e;
    @(negedge clk);
    if (bus.out_valid) begin
      last_out = bus.out;
      ov_q.push_back(cyc);
      if (expq.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        check("out", bus.out, e.val);
        check("out_cycle", cyc, e.due);
      end
    end else if (expq.size() != 0 && expq[0].due <= cyc) begin
      check("out_valid_missing", 0, 1);
      void'(expq.pop_front());
    end
    bus.x_valid = v;
    bus.x_in    = x;
    rst         = r;
    #1;
    check("w_ren", bus.w_ren, v);
    if (r) begin
      xs.delete();
      expq.delete();
    end else if (v) begin
      check("w_raddr", bus.w_raddr, xs.size());
      xs.push_back(x);
      if (xs.size() == NW) begin
        e.val = model_vec();
        e.due = cyc + 4;
        expq.push_back(e);
        xs.delete();
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 20) begin
      cycle(1'b0, DW'($urandom), 1'b0);
      n++;
    end
    if (expq.size() != 0) begin
      check("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    repeat (2) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic send_vec(input int gap_at, input int gap_len);
    for (int i = 0; i < NW; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) cycle(1'b0, DW'($urandom), 1'b0);
      end
      cycle(1'b1, vbuf[i], 1'b0);
    end
  endtask

  task automatic set_w(input logic [DW-1:0] w);
    for (int i = 0; i < NW; i++) wmem[i] = w;
  endtask

  function automatic logic [DW-1:0] rnd_val(input bit big);
    if (big) return DW'($urandom);
    return DW'(int'($urandom_range(0, 2047)) - 1024);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.x_valid = 1'b0;
    bus.x_in    = '0;
    bus.bias    = '0;
    last_out    = '0;
    set_w('0);
    repeat (2) @(negedge clk);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("rst_out", bus.out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_w_raddr", bus.w_raddr, 0);

    // Basic dot product: 1+2+3+4 = 10.0
    set_w(16'h0100);
    vbuf = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_vec(-1, 0);
    drain();
    check("basic_value", last_out, 16'h0A00);

    bus.bias = 32'h0000_8000;
    send_vec(-1, 0);
    drain();
    check("bias_value", last_out, 16'h0A80);

    bus.bias = '0;
    set_w(16'hFF00);
    send_vec(-1, 0);
    drain();
`ifdef NEURON_RELU_EN
    check("sign_value", last_out, 16'h0000);
`else
    check("sign_value", last_out, 16'hF600);
`endif

    set_w(16'h7FFF);
    vbuf = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    send_vec(-1, 0);
    drain();
    check("sat_value", last_out, 16'h7FFF);

    // Two back-to-back vectors, then a third with a 2-cycle gap inside.
    for (int i = 0; i < NW; i++) wmem[i] = rnd_val(1'b0);
    ov_q.delete();
    for (int i = 0; i < NW; i++) vbuf[i] = rnd_val(1'b0);
    send_vec(-1, 0);
    for (int i = 0; i < NW; i++) vbuf[i] = rnd_val(1'b0);
    send_vec(-1, 0);
    for (int i = 0; i < NW; i++) vbuf[i] = rnd_val(1'b0);
    send_vec(2, 2);
    drain();
    check("b2b_count", ov_q.size(), 3);
    if (ov_q.size() == 3) begin
      check("b2b_spacing_1_2", ov_q[1] - ov_q[0], NW);
      check("b2b_spacing_2_3", ov_q[2] - ov_q[1], NW + 2);
    end

    // Reset mid-vector, with x_valid held during the reset cycle.
    set_w(16'h0100);
    vbuf = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_vec(-1, 0);
    drain();
    ov_q.delete();
    cycle(1'b1, 16'h0100, 1'b0);
    cycle(1'b1, 16'h0200, 1'b0);
    cycle(1'b1, 16'h0300, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("midrst_out", bus.out, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_w_raddr", bus.w_raddr, 0);
    vbuf = '{16'h0400, 16'h0300, 16'h0200, 16'h0100};
    send_vec(-1, 0);
    drain();
    check("midrst_count", ov_q.size(), 1);
    check("midrst_value", last_out, 16'h0A00);

    // Randomized batches: new weights and bias per batch, random gaps.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NW; i++) wmem[i] = rnd_val(b % 3 == 2);
      bus.bias = (b % 2 == 1) ? $urandom
                              : 32'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
      for (int v = 0; v < 8; v++) begin
        for (int i = 0; i < NW; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) cycle(1'b0, DW'($urandom), 1'b0);
          end
          cycle(1'b1, rnd_val(b % 3 != 0), 1'b0);
        end
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/neuron_mac.md
# neuron_mac

- Fixed-point multiply-accumulate neuron.
- Consumes a stream of input activations and the matching weight from its per-neuron weight memory.
- Accumulates the dot product, adds a bias, applies optional ReLU and emits one saturated activation per input vector.
- Sits directly downstream of the neuron's weight memory: it drives that memory's read enable and address, and receives its registered output one cycle later.

## Interface
- `numWeight`, 784: inputs per vector (weights per neuron); at least 1, and at most 2**(addressWidth+1).
- `addressWidth`, 10: weight memory address width; the address port is addressWidth+1 bits.
- `dataWidth`, 16: activation/weight width, signed two's complement.
- `fracBits`, 8: fractional bits of activations and weights.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `x_in` in dataWidth: input activation.
- `x_valid` in 1: x_in valid this cycle; one element per cycle, back-to-back allowed, no backpressure.
- `bias` in 2*dataWidth: signed bias, 2*fracBits fractional bits; sampled in the output stage.
- `w_ren` out 1: weight memory read enable.
- `w_raddr` out addressWidth+1: weight memory read address.
- `w_in` in dataWidth: weight memory data, valid one cycle after w_ren.
- `out` out dataWidth: neuron activation, fracBits fractional bits.
- `out_valid` out 1: one-cycle pulse, out valid.

## Operation
- `w_ren = x_valid` (combinational). `w_raddr` = element counter `cnt`, which is 0 after reset.
- `cnt` behaviour on each accepted x_valid:
  - increments by 1;
  - wraps to 0 after numWeight-1, which marks the vector's last element.
- Stage 1, the cycle after x_valid:
  - x_in is held in a register, so it lines up with w_in;
  - valid, first and last flags are pipelined alongside.
- Stage 2 forms `prod = x*w`, a signed 2*dataWidth product, registered.
- Stage 3 updates the accumulator `acc` (signed, 2*dataWidth):
  - on the first element of a vector, `acc` loads `prod`;
  - on every other element, `acc` takes the saturating sum `acc + prod`, clamped to the 2*dataWidth signed min/max.
  - No separate clear cycle is needed, so back-to-back vectors work.
- Stage 4 runs when the last element has been accumulated:
  - `sum` = saturating `acc + bias`;
  - `res` = `sum >>> fracBits` (arithmetic), saturated to the dataWidth signed range;
  - ReLU is applied per Configuration;
  - the result is registered into `out` and `out_valid` pulses for exactly one cycle.
- `out` holds its value until the next result.
- `x_valid` gaps may occur anywhere inside a vector; only valid cycles count.
- Reset:
  - clears `cnt`, all pipeline valid/first/last flags and `acc`;
  - sets `out = 0` and `out_valid = 0`;
  - any partial vector or in-flight result is discarded;
  - the first x_valid after reset is element 0.
- Reset values: `w_ren` follows x_valid (it is combinational); `w_raddr` = 0; `out` = 0; `out_valid` = 0.

## Timing
- Last element accepted in cycle T gives `out_valid` high in cycle T+4.
- Latency is the same for every vector. Throughput is one element per cycle, i.e. one result per numWeight cycles when back-to-back.
- Weight read latency is fixed at 1 cycle. The memory must register its output on ren; no other latency is supported.
- A new vector may begin at T+1 while the previous one is still draining. Results stay in order, with pulses exactly numWeight cycles apart.
- x_valid asserted together with rst is ignored.

## Configuration
- `NEURON_RELU_EN` defined: ReLU is applied; a negative saturated result gives `out` = 0.
- `NEURON_RELU_EN` undefined: `out` is the saturated signed result, a linear neuron.
- Latency is identical either way.

## Test plan
- Basic dot product:
  - stimulus: numWeight=4, weights all 0x0100, x = 0x0100, 0x0200, 0x0300, 0x0400 back-to-back, bias 0;
  - response: w_raddr 0,1,2,3; out = 0x0A00, with out_valid 4 cycles after the last x_valid.
- Bias:
  - stimulus: same as basic, with bias = 0x00008000;
  - response: out = 0x0A80.
- Sign and ReLU:
  - stimulus: weights 0xFF00 (-1.0), same inputs;
  - response: out = 0x0000 with NEURON_RELU_EN, 0xF600 without.
- Saturation:
  - stimulus: x and w all 0x7FFF, numWeight=4;
  - response: acc clamps at 0x7FFFFFFF and out = 0x7FFF.
- Back-to-back with a gap:
  - stimulus: two vectors sent consecutively, then a third with a 2-cycle x_valid gap;
  - response: three correct results; the first two are exactly 4 cycles apart, and the third is delayed by 2 cycles.
- Reset mid-vector:
  - stimulus: rst for 1 cycle after 2 elements, then a full vector;
  - response: outputs 0 during reset, w_raddr restarts at 0, exactly one out_valid with the correct value.
